// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the fetch front-end sequencer: FSM states, redirect sources
// ordered so that a larger encoding means higher priority, and the redirect record.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_JUMP   = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_TRAP   = 2'd3
  } redirect_src_e;

  typedef struct packed {
    redirect_src_e src;
    logic [31:0]   addr;
  } redirect_t;

  localparam redirect_t REDIRECT_NONE = '{src: SRC_NONE, addr: 32'h0};

  // Fixed-priority pick among same-cycle requests; losers are simply discarded.
  function automatic redirect_t pick_request(
    input logic        trap,
    input logic [31:0] trap_addr,
    input logic        branch,
    input logic [31:0] branch_addr,
    input logic        jump,
    input logic [31:0] jump_addr
  );
    redirect_t r;
    r = REDIRECT_NONE;
    if (trap) begin
      r.src  = SRC_TRAP;
      r.addr = trap_addr;
    end else if (branch) begin
      r.src  = SRC_BRANCH;
      r.addr = branch_addr;
    end else if (jump) begin
      r.src  = SRC_JUMP;
      r.addr = jump_addr;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Fetch front-end sequencer: boot/halt FSM, redirect arbitration with a one-entry
// pending buffer for redirects raised while fetch is stalled, stall/flush generation.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trap_req,
  input  logic [31:0]      trap_addr,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_addr,
  input  logic             id_jump,
  input  logic [31:0]      id_jump_addr,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  input  logic             load_use_hazard,
  input  logic             halt_req,
  input  logic             resume_req,
  output logic             fetch_valid,
  output logic             fetch_stall,
  output logic             fetch_branch,
  output logic [31:0]      fetch_branch_addr,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int             BW        = $clog2(BOOT_CYCLES + 1);
  localparam logic [BW-1:0]  BOOT_LAST = BW'(BOOT_CYCLES - 1);

  state_e        state;
  logic [BW-1:0] boot_cnt;
  redirect_t     pending;

  redirect_t     new_req;
  redirect_t     sel;
  logic          run;
  logic          stall_raw;
  logic          req_any;
  logic          use_new;
  logic          redirect_en;
  logic          stall_en;

  // Arbitration and per-stage controls, all combinational for zero-latency delivery
  always_comb begin
    new_req   = pick_request(trap_req, trap_addr, ex_branch_taken, ex_branch_addr,
                             id_jump, id_jump_addr);
    req_any   = trap_req | ex_branch_taken | id_jump;
    run       = (state == RUN);
    stall_raw = imem_wait | dmem_wait | load_use_hazard;
    use_new   = (new_req.src != SRC_NONE) && (new_req.src >= pending.src);
    sel       = use_new ? new_req : pending;

    fetch_stall       = run & stall_raw;
    fetch_branch      = run & ~stall_raw & (sel.src != SRC_NONE);
    fetch_branch_addr = fetch_branch ? sel.addr : 32'h0;

    flush_id = run & (new_req.src != SRC_NONE);
    flush_ex = run & ((new_req.src == SRC_TRAP) | (new_req.src == SRC_BRANCH) |
                      (load_use_hazard & ~dmem_wait));
    // A flush takes precedence over holding the same register.
    stall_id = run & (dmem_wait | load_use_hazard) & ~flush_id;
    stall_ex = run & dmem_wait & ~flush_ex;

    redirect_en = fetch_branch & ~fetch_stall;
    stall_en    = run & fetch_stall;
  end

  // Sequencer state, pending redirect and registered state decodes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      pending     <= REDIRECT_NONE;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (boot_cnt == BOOT_LAST) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + 1'b1;
          end
        end
        RUN: begin
          if (stall_raw) begin
            if (use_new) begin
              pending <= new_req;
            end
          end else begin
            pending <= REDIRECT_NONE;
          end
          if (halt_req && !req_any && (pending.src == SRC_NONE)) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end
        end
        HALT: begin
          if (trap_req) begin
            pending <= '{src: SRC_TRAP, addr: trap_addr};
          end
          if (trap_req || resume_req) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
            halted      <= 1'b0;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (redirect_en),
    .count (redirect_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_en),
    .count (stall_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a scoreboard of expected redirect targets.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             trap_req, ex_branch_taken, id_jump;
  logic [31:0]      trap_addr, ex_branch_addr, id_jump_addr;
  logic             imem_wait, dmem_wait, load_use_hazard, halt_req, resume_req;
  logic             fetch_valid, fetch_stall, fetch_branch;
  logic [31:0]      fetch_branch_addr;
  logic             stall_id, stall_ex, flush_id, flush_ex, halted;
  logic [CNT_W-1:0] redirect_count, stall_count;

  int          checks = 0;
  int          errors = 0;
  int          red_model = 0;
  logic [31:0] exp_q[$];

  pipeline_ctrl #(.BOOT_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .trap_req          (trap_req),
    .trap_addr         (trap_addr),
    .ex_branch_taken   (ex_branch_taken),
    .ex_branch_addr    (ex_branch_addr),
    .id_jump           (id_jump),
    .id_jump_addr      (id_jump_addr),
    .imem_wait         (imem_wait),
    .dmem_wait         (dmem_wait),
    .load_use_hazard   (load_use_hazard),
    .halt_req          (halt_req),
    .resume_req        (resume_req),
    .fetch_valid       (fetch_valid),
    .fetch_stall       (fetch_stall),
    .fetch_branch      (fetch_branch),
    .fetch_branch_addr (fetch_branch_addr),
    .stall_id          (stall_id),
    .stall_ex          (stall_ex),
    .flush_id          (flush_id),
    .flush_ex          (flush_ex),
    .halted            (halted),
    .redirect_count    (redirect_count),
    .stall_count       (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    trap_req = 0; ex_branch_taken = 0; id_jump = 0;
    trap_addr = 0; ex_branch_addr = 0; id_jump_addr = 0;
    imem_wait = 0; dmem_wait = 0; load_use_hazard = 0;
    halt_req = 0; resume_req = 0;
  endtask

  // Scoreboard: every delivered redirect must match the oldest expected target.
  always @(negedge clk) begin
    if (fetch_branch === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_redirect", fetch_branch_addr, 32'hFFFF_FFFF);
      end else begin
        check("redirect_addr", fetch_branch_addr, exp_q.pop_front());
      end
      red_model = (red_model == (1 << CNT_W) - 1) ? red_model : red_model + 1;
    end else begin
      check("addr_idle_zero", fetch_branch_addr, 32'h0);
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_redirect_count", {28'b0, redirect_count}, 32'h0);
    check("rst_stall_count", {28'b0, stall_count}, 32'h0);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("boot_valid_c%0d", k), {31'b0, fetch_valid}, (k == 3) ? 32'h1 : 32'h0);
    end

    // Branch beats same-cycle jump, no stall
    next_cycle();
    ex_branch_taken = 1; ex_branch_addr = 32'h100;
    id_jump = 1; id_jump_addr = 32'h200;
    exp_q.push_back(32'h100);
    @(negedge clk);
    check("br_fetch_branch", {31'b0, fetch_branch}, 32'h1);
    check("br_addr", fetch_branch_addr, 32'h100);
    check("br_flush_id", {31'b0, flush_id}, 32'h1);
    check("br_flush_ex", {31'b0, flush_ex}, 32'h1);
    check("br_count_before", {28'b0, redirect_count}, 32'h0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("br_count_after", {28'b0, redirect_count}, 32'h1);
    check("br_once", {31'b0, fetch_branch}, 32'h0);

    // dmem stall: jump then trap captured, trap delivered once
    next_cycle();
    dmem_wait = 1; id_jump = 1; id_jump_addr = 32'h40;
    @(negedge clk);
    check("st1_fetch_branch", {31'b0, fetch_branch}, 32'h0);
    check("st1_fetch_stall", {31'b0, fetch_stall}, 32'h1);
    check("st1_stall_ex", {31'b0, stall_ex}, 32'h1);
    check("st1_flush_id", {31'b0, flush_id}, 32'h1);
    next_cycle();
    id_jump = 0; trap_req = 1; trap_addr = 32'h80;
    exp_q.push_back(32'h80);
    @(negedge clk);
    check("st2_fetch_branch", {31'b0, fetch_branch}, 32'h0);
    next_cycle();
    trap_req = 0;
    @(negedge clk);
    check("st3_fetch_branch", {31'b0, fetch_branch}, 32'h0);
    check("st3_stall_id", {31'b0, stall_id}, 32'h1);
    check("st3_stall_ex", {31'b0, stall_ex}, 32'h1);
    next_cycle();
    dmem_wait = 0;
    @(negedge clk);
    check("st4_fetch_branch", {31'b0, fetch_branch}, 32'h1);
    check("st4_stall_count", {28'b0, stall_count}, 32'h3);
    next_cycle();
    @(negedge clk);
    check("st5_once", {31'b0, fetch_branch}, 32'h0);

    // Load-use bubble
    next_cycle();
    load_use_hazard = 1;
    @(negedge clk);
    check("lu_fetch_stall", {31'b0, fetch_stall}, 32'h1);
    check("lu_stall_id", {31'b0, stall_id}, 32'h1);
    check("lu_stall_ex", {31'b0, stall_ex}, 32'h0);
    check("lu_flush_ex", {31'b0, flush_ex}, 32'h1);
    check("lu_flush_id", {31'b0, flush_id}, 32'h0);
    next_cycle();
    load_use_hazard = 0;
    @(negedge clk);
    check("lu_stall_count", {28'b0, stall_count}, 32'h4);

    // Halt, branch ignored in HALT, trap resumes and redirects
    next_cycle();
    halt_req = 1;
    @(negedge clk);
    check("halt_pre", {31'b0, halted}, 32'h0);
    next_cycle();
    halt_req = 0; ex_branch_taken = 1; ex_branch_addr = 32'h777;
    @(negedge clk);
    check("halt_halted", {31'b0, halted}, 32'h1);
    check("halt_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("halt_no_branch", {31'b0, fetch_branch}, 32'h0);
    next_cycle();
    ex_branch_taken = 0; trap_req = 1; trap_addr = 32'h10;
    exp_q.push_back(32'h10);
    @(negedge clk);
    check("halt_trap_cycle", {31'b0, fetch_branch}, 32'h0);
    next_cycle();
    trap_req = 0;
    @(negedge clk);
    check("resume_halted", {31'b0, halted}, 32'h0);
    check("resume_valid", {31'b0, fetch_valid}, 32'h1);
    check("resume_branch", {31'b0, fetch_branch}, 32'h1);

    // Pending trap beats a later lower-priority jump
    next_cycle();
    imem_wait = 1; trap_req = 1; trap_addr = 32'h300;
    exp_q.push_back(32'h300);
    @(negedge clk);
    check("pend_flush_ex", {31'b0, flush_ex}, 32'h1);
    check("pend_stall_id", {31'b0, stall_id}, 32'h0);
    next_cycle();
    imem_wait = 0; trap_req = 0; id_jump = 1; id_jump_addr = 32'h400;
    @(negedge clk);
    check("pend_wins", {31'b0, fetch_branch}, 32'h1);
    next_cycle();
    clear_inputs();

    // Equal-priority request replaces pending
    imem_wait = 1; id_jump = 1; id_jump_addr = 32'h500;
    next_cycle();
    id_jump_addr = 32'h600;
    exp_q.push_back(32'h600);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("eq_replace", {31'b0, fetch_branch}, 32'h1);

    // Saturation of redirect_count
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      id_jump = 1; id_jump_addr = 32'h1000 + 32'(i);
      exp_q.push_back(32'h1000 + 32'(i));
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("sat_model", {28'b0, redirect_count}, 32'(red_model));
    check("sat_allones", {28'b0, redirect_count}, 32'hF);

    // Reset mid-operation with a redirect pending
    next_cycle();
    dmem_wait = 1; trap_req = 1; trap_addr = 32'h900;
    @(negedge clk);
    check("mid_capture_no_branch", {31'b0, fetch_branch}, 32'h0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("mid_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("mid_fetch_stall", {31'b0, fetch_stall}, 32'h0);
    check("mid_stall_id", {31'b0, stall_id}, 32'h0);
    check("mid_flush_ex", {31'b0, flush_ex}, 32'h0);
    check("mid_redirect_count", {28'b0, redirect_count}, 32'h0);
    check("mid_stall_count", {28'b0, stall_count}, 32'h0);
    red_model = 0;
    clear_inputs();
    next_cycle();
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("reboot_valid_c%0d", k), {31'b0, fetch_valid}, (k == 3) ? 32'h1 : 32'h0);
    end
    check("pending_lost", {31'b0, fetch_branch}, 32'h0);
    check("reboot_redirect_count", {28'b0, redirect_count}, 32'h0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Front-end sequencer for the fetch stage. It drives the fetch stage's valid, stall and branch/redirect inputs. It arbitrates redirect requests from trap, execute-stage branch and decode-stage jump, and holds a redirect that arrives while fetch is stalled until it can be delivered. It also generates per-stage stall/flush controls, sequences boot and halt/resume, and keeps saturating performance counters.

Parameters:
BOOT_CYCLES, 2, cycles in BOOT after reset release before fetch becomes valid (>=1)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
trap_req  in  1  trap/exception redirect request
trap_addr  in  32  trap target
ex_branch_taken  in  1  execute-stage taken branch
ex_branch_addr  in  32  branch target
id_jump  in  1  decode-stage jump
id_jump_addr  in  32  jump target
imem_wait  in  1  instruction memory not ready
dmem_wait  in  1  data memory not ready
load_use_hazard  in  1  decode needs an in-flight load result
halt_req  in  1  request halt (level)
resume_req  in  1  leave halt (level)
fetch_valid  out  1  to fetch valid_input
fetch_stall  out  1  to fetch stall_input
fetch_branch  out  1  to fetch branch_input
fetch_branch_addr  out  32  to fetch branch_dest_address
stall_id  out  1  hold IF/ID register
stall_ex  out  1  hold ID/EX register
flush_id  out  1  bubble into IF/ID
flush_ex  out  1  bubble into ID/EX
halted  out  1  state==HALT
redirect_count  out  CNT_W  delivered redirects, saturating
stall_count  out  CNT_W  RUN cycles with fetch_stall=1, saturating

Behaviour:
- Reset (async, rst=0): state=BOOT, boot counter=0, pending redirect empty, both counters=0. All outputs are 0 while in reset and in BOOT.
- States: BOOT, RUN, HALT.
  - BOOT -> RUN after exactly BOOT_CYCLES clock edges following reset release.
  - RUN -> HALT when halt_req=1, no redirect is requested this cycle, and pending is empty.
  - HALT -> RUN on resume_req=1 or trap_req=1.
- fetch_valid=1 only in RUN. halted=1 only in HALT.
- Stall generation (RUN only):
  - fetch_stall = imem_wait | dmem_wait | load_use_hazard.
  - stall_id = dmem_wait | load_use_hazard.
  - stall_ex = dmem_wait.
  - load_use_hazard & ~dmem_wait asserts flush_ex (bubble).
- Redirect priority: trap > ex_branch > id_jump. Lower-priority same-cycle requests are discarded.
- Flushes in the request cycle (RUN), OR-ed with the load-use bubble:
  - trap and ex_branch: flush_id=1, flush_ex=1.
  - id_jump: flush_id=1 only.
  - A flush overrides the stall for that register.
- Delivery when fetch_stall=0:
  - fetch_branch=1 and fetch_branch_addr=target, combinationally in the same cycle (zero latency).
  - Pending has precedence over a new request of lower priority. A new request of higher or equal priority than pending wins and clears pending.
- Capture when fetch_stall=1:
  - The winning request is latched into pending. It replaces an existing pending entry only if its priority is >= the pending entry's; otherwise it is dropped.
  - fetch_branch=0 while stalled.
  - Pending is delivered on the first cycle with fetch_stall=0, then cleared at that edge.
- trap_req in HALT: latched into pending, state->RUN next cycle, delivered on the first unstalled RUN cycle.
- trap_req in BOOT is ignored.
- fetch_branch_addr=0 when fetch_branch=0.
- Counters:
  - redirect_count increments when fetch_branch & ~fetch_stall.
  - stall_count increments when state==RUN & fetch_stall.
  - Both saturate at all-ones.
- Reset asserted mid-operation: immediate return to the reset values above, and any pending redirect is lost.

Decomposition:
- pipeline_ctrl_pkg holds:
  - state_e {BOOT, RUN, HALT}.
  - redirect_src_e {SRC_NONE=0, SRC_JUMP=1, SRC_BRANCH=2, SRC_TRAP=3}, encoded so numeric compare gives priority.
  - redirect_t struct {src, addr[31:0]}.
- One sub-module, sat_counter (CNT_W, enable, async active-low clear), instantiated twice.

Test Plan:
- Reset release, no requests -> fetch_valid=0 for 2 cycles, 1 on cycle 3. Holding rst=0 mid-run -> all outputs 0 immediately.
- RUN, ex_branch_taken=1 addr=0x100 with id_jump=1 addr=0x200 same cycle, no stall -> fetch_branch=1, addr=0x100, flush_id=flush_ex=1, redirect_count 0->1.
- dmem_wait=1 for 3 cycles, id_jump 0x40 in cycle 1, trap 0x80 in cycle 2 -> fetch_branch=0 during stall, stall_id=stall_ex=1. First unstalled cycle: fetch_branch=1 addr=0x80, once only.
- load_use_hazard=1 alone -> fetch_stall=1, stall_id=1, stall_ex=0, flush_ex=1, stall_count increments.
- halt_req=1 in RUN -> halted=1 next cycle, fetch_valid=0. trap_req addr=0x10 in HALT -> RUN next cycle, fetch_branch=1 addr=0x10.
- Force redirect_count to all-ones via 2^CNT_W redirects (CNT_W=4 build) -> counter stays 0xF.
